// File: rtl/buffer_filler.sv
// buffer_filler: fetches 32-bit words over a req/valid handshake and fills/refills the 8x8 byte buffer.
// Build option FILLER_BYTE_SWAP_EN: byte-reverse every word written to the buffer.
module buffer_filler #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned REFILL_ADDR = 60
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              shift_req,
   output logic              mem_rd_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rd_valid,
   input  logic [31:0]       mem_rd_data,
   output logic              buf_wr_en,
   output logic [5:0]        buf_wr_addr,
   output logic [31:0]       buf_wr_data,
   output logic              buf_shift_en,
   output logic              ready,
   output logic              done
);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] FILL_REQ   = 3'd1;
   localparam logic [2:0] FILL_WR    = 3'd2;
   localparam logic [2:0] READY_ST   = 3'd3;
   localparam logic [2:0] SHIFT      = 3'd4;
   localparam logic [2:0] REFILL_REQ = 3'd5;
   localparam logic [2:0] REFILL_WR  = 3'd6;

   logic [2:0]        state, state_d;
   logic [ADDR_W-1:0] ptr, ptr_d;
   logic [3:0]        k, k_d;

   logic              mem_rd_req_d, buf_wr_en_d, buf_shift_en_d, ready_d, done_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [5:0]        buf_wr_addr_d;
   logic [31:0]       buf_wr_data_d;

   logic              accept;
   logic [31:0]       wr_word;

   assign accept = mem_rd_req & mem_rd_valid;

`ifdef FILLER_BYTE_SWAP_EN
   assign wr_word = {mem_rd_data[7:0], mem_rd_data[15:8], mem_rd_data[23:16], mem_rd_data[31:24]};
`else
   assign wr_word = mem_rd_data;
`endif

   // Next state plus next value of every registered output; the returned word is captured straight into buf_wr_data.
   always_comb begin
      state_d        = state;
      ptr_d          = ptr;
      k_d            = k;
      mem_rd_req_d   = 1'b0;
      mem_addr_d     = mem_addr;
      buf_wr_en_d    = 1'b0;
      buf_wr_addr_d  = buf_wr_addr;
      buf_wr_data_d  = buf_wr_data;
      buf_shift_en_d = 1'b0;
      ready_d        = 1'b0;
      done_d         = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               ptr_d        = base_addr;
               k_d          = 4'd0;
               state_d      = FILL_REQ;
               mem_rd_req_d = 1'b1;
               mem_addr_d   = base_addr;
            end
         end
         FILL_REQ: begin
            if (accept) begin
               ptr_d         = ptr + ADDR_W'(1);
               state_d       = FILL_WR;
               buf_wr_en_d   = 1'b1;
               buf_wr_addr_d = {k, 2'b00};
               buf_wr_data_d = wr_word;
               done_d        = (k == 4'd15);
            end else begin
               mem_rd_req_d = 1'b1;
            end
         end
         FILL_WR: begin
            if (k == 4'd15) begin
               state_d = READY_ST;
               ready_d = 1'b1;
            end else begin
               k_d          = k + 4'd1;
               state_d      = FILL_REQ;
               mem_rd_req_d = 1'b1;
               mem_addr_d   = ptr;
            end
         end
         READY_ST: begin
            if (shift_req) begin
               state_d        = SHIFT;
               buf_shift_en_d = 1'b1;
            end else begin
               ready_d = 1'b1;
            end
         end
         SHIFT: begin
            state_d      = REFILL_REQ;
            mem_rd_req_d = 1'b1;
            mem_addr_d   = ptr;
         end
         REFILL_REQ: begin
            if (accept) begin
               ptr_d         = ptr + ADDR_W'(1);
               state_d       = REFILL_WR;
               buf_wr_en_d   = 1'b1;
               buf_wr_addr_d = 6'(REFILL_ADDR);
               buf_wr_data_d = wr_word;
               done_d        = 1'b1;
            end else begin
               mem_rd_req_d = 1'b1;
            end
         end
         REFILL_WR: begin
            state_d = READY_ST;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ptr          <= '0;
         k            <= '0;
         mem_rd_req   <= 1'b0;
         mem_addr     <= '0;
         buf_wr_en    <= 1'b0;
         buf_wr_addr  <= '0;
         buf_wr_data  <= '0;
         buf_shift_en <= 1'b0;
         ready        <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_d;
         ptr          <= ptr_d;
         k            <= k_d;
         mem_rd_req   <= mem_rd_req_d;
         mem_addr     <= mem_addr_d;
         buf_wr_en    <= buf_wr_en_d;
         buf_wr_addr  <= buf_wr_addr_d;
         buf_wr_data  <= buf_wr_data_d;
         buf_shift_en <= buf_shift_en_d;
         ready        <= ready_d;
         done         <= done_d;
      end
   end

endmodule

// File: tb/tb_buffer_filler.sv
// tb_buffer_filler: drives buffer_filler against a memory model and a write scoreboard.
`timescale 1ns/1ps
module tb_buffer_filler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start, shift_req;
   logic [15:0] base_addr;
   logic        mem_rd_req;
   logic [15:0] mem_addr;
   logic        mem_rd_valid = 1'b0;
   logic [31:0] mem_rd_data  = 32'h0;
   logic        buf_wr_en;
   logic [5:0]  buf_wr_addr;
   logic [31:0] buf_wr_data;
   logic        buf_shift_en, ready, done;

`ifdef FILLER_BYTE_SWAP_EN
   localparam logic [31:0] EXP_SWAP = 32'h44332211;
`else
   localparam logic [31:0] EXP_SWAP = 32'h11223344;
`endif

   typedef struct packed {
      logic [5:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_wr[$];
   logic [15:0] exp_addr[$];
   logic [15:0] mptr;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_wr = 0, n_shift = 0;
   logic [31:0] first_data = 32'h0;

   logic        plain = 1'b1;
   logic [15:0] salt = 16'h0;
   int          mem_delay = 0;
   bit          mem_delay_rand = 1'b0;
   bit          stray_valid = 1'b0;
   bit          stall_en = 1'b0;
   logic [15:0] stall_addr = 16'h0;

   buffer_filler dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .shift_req(shift_req),
      .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_valid(mem_rd_valid),
      .mem_rd_data(mem_rd_data), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
      .buf_wr_data(buf_wr_data), .buf_shift_en(buf_shift_en), .ready(ready), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      if (a == 16'h0200) return 32'h11223344;
      if (plain) return {16'h0000, a};
      return {a ^ salt, ~a};
   endfunction

   function automatic logic [31:0] exp_data(input logic [15:0] a);
      logic [31:0] d;
      d = mem_word(a);
`ifdef FILLER_BYTE_SWAP_EN
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
      return d;
`endif
   endfunction

   // Memory: answers each request after a (possibly random) wait, checks address order and stability.
   int          cnt = 0, cur_delay = 0;
   bit          pend = 1'b0;
   logic [15:0] pend_addr = 16'h0;
   always @(negedge clk) begin
      if (rst || !mem_rd_req) begin
         mem_rd_valid = stray_valid;
         cnt  = 0;
         pend = 1'b0;
      end else begin
         if (pend) check("addr_stable", mem_addr, pend_addr);
         if (!pend) begin
            pend      = 1'b1;
            pend_addr = mem_addr;
            cur_delay = mem_delay_rand ? int'($urandom_range(0, 3)) : mem_delay;
         end
         if (stall_en && mem_addr == stall_addr) begin
            mem_rd_valid = stray_valid;
         end else if (cnt >= cur_delay) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mem_word(mem_addr);
            check("addr_q_nonempty", 64'(exp_addr.size() != 0), 1);
            if (exp_addr.size() != 0) check("mem_addr", mem_addr, exp_addr.pop_front());
         end else begin
            mem_rd_valid = 1'b0;
            cnt++;
         end
      end
   end

   // Buffer-side scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (buf_wr_en) begin
            wr_t e;
            n_wr++;
            check("wr_shift_excl", buf_shift_en, 0);
            check("wr_q_nonempty", 64'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
               e = exp_wr.pop_front();
               check("wr_addr", buf_wr_addr, e.addr);
               check("wr_data", buf_wr_data, e.data);
            end
            if (buf_wr_addr == 6'd0) first_data = buf_wr_data;
         end
         if (buf_shift_en) n_shift++;
      end
   end

   task automatic push_fill(input logic [15:0] b);
      wr_t e;
      mptr = b;
      for (int i = 0; i < 16; i++) begin
         exp_addr.push_back(mptr);
         e.addr = 6'(4 * i);
         e.data = exp_data(mptr);
         exp_wr.push_back(e);
         mptr = mptr + 16'd1;
      end
   endtask

   task automatic check_zero_outs(input string tag);
      check(tag, {mem_rd_req, mem_addr, buf_wr_en, buf_wr_addr, buf_wr_data, buf_shift_en, ready, done}, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; shift_req = 1'b0;
      repeat (2) @(negedge clk);
      exp_wr.delete(); exp_addr.delete();
      check_zero_outs("rst_outs");
      rst = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 1;
      while (!done && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      check("done_seen", done, 1);
   endtask

   task automatic run_fill(input logic [15:0] b, input int budget, input int exp_cyc);
      int cyc, w0;
      push_fill(b);
      w0 = n_wr;
      start = 1'b1; base_addr = b;
      @(negedge clk);
      start = 1'b0; base_addr = 16'($urandom);
      wait_done(budget, cyc);
      if (exp_cyc > 0) check("fill_latency", cyc, exp_cyc);
      @(negedge clk);
      check("fill_writes", n_wr - w0, 16);
      check("fill_ready", ready, 1);
      check("done_pulse", done, 0);
      check("fill_q_empty", exp_wr.size(), 0);
   endtask

   task automatic run_slide(input int budget, input int exp_cyc);
      int cyc, w0, s0;
      wr_t e;
      exp_addr.push_back(mptr);
      e.addr = 6'd60;
      e.data = exp_data(mptr);
      exp_wr.push_back(e);
      mptr = mptr + 16'd1;
      w0 = n_wr; s0 = n_shift;
      shift_req = 1'b1;
      @(negedge clk);
      shift_req = 1'b0;
      check("slide_ready_drop", ready, 0);
      wait_done(budget, cyc);
      if (exp_cyc > 0) check("slide_latency", cyc, exp_cyc);
      @(negedge clk);
      check("slide_shifts", n_shift - s0, 1);
      check("slide_writes", n_wr - w0, 1);
      check("slide_ready", ready, 1);
      check("slide_q_empty", exp_wr.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, s0, lim;
      start = 1'b0; shift_req = 1'b0; base_addr = 16'h0;

      // zero-wait fill from 0x0100, then two slides
      do_reset();
      run_fill(16'h0100, 100, 32);
      run_slide(20, 3);
      run_slide(20, 3);

      // three-cycle memory wait on every word
      do_reset();
      mem_delay = 3;
      run_fill(16'h0040, 200, 80);
      mem_delay = 0;

      // address wrap
      do_reset();
      run_fill(16'hFFFE, 100, 32);
      run_slide(20, 3);

      // byte ordering of a known word
      do_reset();
      run_fill(16'h0200, 100, 32);
      check("swap_word", first_data, EXP_SWAP);

      // reset during the 7th request with valid present
      do_reset();
      stall_en = 1'b1; stall_addr = 16'h0306;
      push_fill(16'h0300);
      start = 1'b1; base_addr = 16'h0300;
      @(negedge clk);
      start = 1'b0;
      lim = 0;
      while (!(mem_rd_req && mem_addr == stall_addr) && lim < 100) begin
         @(negedge clk);
         lim++;
      end
      check("seventh_req_seen", {mem_rd_req, mem_addr}, {1'b1, stall_addr});
      stray_valid = 1'b1; rst = 1'b1;
      repeat (2) @(negedge clk);
      exp_wr.delete(); exp_addr.delete();
      check_zero_outs("abort_outs");
      rst = 1'b0;
      w0 = n_wr;
      repeat (3) begin
         @(negedge clk);
         check("stray_req", mem_rd_req, 0);
      end
      stray_valid = 1'b0; stall_en = 1'b0;
      @(negedge clk);
      check("stray_writes", n_wr - w0, 0);
      check_zero_outs("stray_outs");

      // shift_req in IDLE is ignored
      s0 = n_shift;
      shift_req = 1'b1;
      @(negedge clk);
      shift_req = 1'b0;
      repeat (4) @(negedge clk);
      check("idle_shift_ign", n_shift - s0, 0);
      check("idle_no_req", mem_rd_req, 0);

      // start in READY is ignored
      run_fill(16'h0500, 100, 32);
      w0 = n_wr;
      start = 1'b1; base_addr = 16'h0700;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("ready_start_req", mem_rd_req, 0);
      check("ready_start_rdy", ready, 1);
      check("ready_start_wr", n_wr - w0, 0);
      run_slide(20, 3);

      // randomized bases, data, memory waits and slide gaps
      for (int it = 0; it < 3; it++) begin
         plain = 1'b0;
         salt = 16'($urandom);
         do_reset();
         mem_delay_rand = 1'b1;
         run_fill(16'($urandom), 400, 0);
         for (int s = 0; s < int'($urandom_range(2, 4)); s++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_slide(50, 0);
         end
         mem_delay_rand = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
